// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency RV32I data-memory responder
// Valid/ready request and response channels, byte-lane stores, extended loads, error responses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_busy
);

   localparam int          ADDR_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_err;
   logic [31:0] r_rdata;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic              w_accept;
   logic              w_access;
   logic              w_req_err;
   logic              w_a_we;
   logic [2:0]        w_a_funct3;
   logic [31:0]       w_a_addr;
   logic [31:0]       w_a_wdata;
   logic              w_a_err;
   logic [ADDR_W-1:0] w_word_idx;
   logic [31:0]       w_rword;
   logic [31:0]       w_shifted;
   logic [31:0]       w_load;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata_rep;

   function automatic logic f_err(input logic [2:0] f3, input logic [31:0] addr);
      logic e;
      case (f3)
         3'b000, 3'b100: e = 1'b0;
         3'b001, 3'b101: e = addr[0];
         3'b010:         e = |addr[1:0];
         default:        e = 1'b1;
      endcase
      return e | ({1'b0, addr} >= ADDR_LIMIT);
   endfunction

   assign w_accept  = (r_state == S_IDLE) && i_req_valid;
   assign w_req_err = f_err(i_req_funct3, i_req_addr);

   // With LATENCY=1 the array access happens on the accept edge straight from the inputs.
   assign w_access   = (LATENCY == 1) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0));
   assign w_a_we     = (LATENCY == 1) ? i_req_we     : r_we;
   assign w_a_funct3 = (LATENCY == 1) ? i_req_funct3 : r_funct3;
   assign w_a_addr   = (LATENCY == 1) ? i_req_addr   : r_addr;
   assign w_a_wdata  = (LATENCY == 1) ? i_req_wdata  : r_wdata;
   assign w_a_err    = (LATENCY == 1) ? w_req_err    : r_err;

   assign w_word_idx = w_a_addr[ADDR_W+1:2];
   assign w_rword    = r_mem[w_word_idx];
   assign w_shifted  = w_rword >> {w_a_addr[1:0], 3'b000};

   always_comb begin
      w_load = 32'd0;
      case (w_a_funct3)
         3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_load = w_rword;
         3'b100:  w_load = {24'd0, w_shifted[7:0]};
         3'b101:  w_load = {16'd0, w_shifted[15:0]};
         default: w_load = 32'd0;
      endcase
   end

   always_comb begin
      w_be        = 4'b0000;
      w_wdata_rep = w_a_wdata;
      case (w_a_funct3[1:0])
         2'b00: begin
            w_be        = 4'b0001 << w_a_addr[1:0];
            w_wdata_rep = {4{w_a_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = w_a_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata_rep = {2{w_a_wdata[15:0]}};
         end
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // Array is deliberately not reset; a reset at the commit edge suppresses the write.
   always_ff @(posedge i_clk) begin
      if (w_access && w_a_we && !w_a_err && !i_reset) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_req_valid) w_state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt     <= 4'd0;
         r_we      <= 1'b0;
         r_funct3  <= 3'd0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_err     <= 1'b0;
         r_rdata   <= 32'd0;
         r_rsp_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_err    <= w_req_err;
            r_cnt    <= CNT_INIT;
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_access) begin
            r_rdata   <= (w_a_we || w_a_err) ? 32'd0 : w_load;
            r_rsp_err <= w_a_err;
         end else if ((r_state == S_RESP) && i_rsp_ready) begin
            r_rdata   <= 32'd0;
            r_rsp_err <= 1'b0;
         end
      end
   end

   assign o_rsp_rdata = r_rdata;
   assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
// Main instance at LATENCY=2, second instance at LATENCY=1 for back-to-back throughput.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [31:0] rsp_rdata;

   logic        req_valid1, req_ready1, req_we1;
   logic [2:0]  req_funct31;
   logic [31:0] req_addr1, req_wdata1;
   logic        rsp_valid1, rsp_err1, busy1;
   logic [31:0] rsp_rdata1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
      .i_clk(clk), .i_reset(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_rsp_err(rsp_err), .o_busy(busy)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
      .i_clk(clk), .i_reset(rst),
      .i_req_valid(req_valid1), .o_req_ready(req_ready1), .i_req_we(req_we1),
      .i_req_funct3(req_funct31), .i_req_addr(req_addr1), .i_req_wdata(req_wdata1),
      .o_rsp_valid(rsp_valid1), .i_rsp_ready(1'b1), .o_rsp_rdata(rsp_rdata1),
      .o_rsp_err(rsp_err1), .o_busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rdata"},     rsp_rdata,      32'd0);
      check({tag, "_err"},       32'(rsp_err),   32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   // One full transaction on the LATENCY=2 instance, holding off the response for 'hold' cycles.
   task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      bit got;
      @(negedge clk);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
      end
      check({tag, "_latency"}, 32'(lat), 32'd2);
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
         check({tag, "_hold_err"},   32'(rsp_err), 32'(exp_err));
         check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
         check({tag, "_hold_busy"},  32'(busy), 32'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_done_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_done_err"},   32'(rsp_err), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'hC00; req_wdata = 32'hDEADBEEF;
      rsp_ready = 1'b0;
      req_valid1 = 1'b0; req_we1 = 1'b0; req_funct31 = 3'b010; req_addr1 = 32'h0; req_wdata1 = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("post_reset");

      xact("sw_c00",  1'b1, 3'b010, 32'hC00, 32'hABCD1234, 0, 32'h0,        1'b0);
      xact("lw_c00",  1'b0, 3'b010, 32'hC00, 32'h0,        0, 32'hABCD1234, 1'b0);
      xact("sb_c01",  1'b1, 3'b000, 32'hC01, 32'h00000080, 0, 32'h0,        1'b0);
      xact("lb_c01",  1'b0, 3'b000, 32'hC01, 32'h0,        0, 32'hFFFFFF80, 1'b0);
      xact("lbu_c01", 1'b0, 3'b100, 32'hC01, 32'h0,        0, 32'h00000080, 1'b0);
      xact("lw_sb",   1'b0, 3'b010, 32'hC00, 32'h0,        0, 32'hABCD8034, 1'b0);
      xact("lhu_c02", 1'b0, 3'b101, 32'hC02, 32'h0,        0, 32'h0000ABCD, 1'b0);
      xact("lh_c02",  1'b0, 3'b001, 32'hC02, 32'h0,        0, 32'hFFFFABCD, 1'b0);

      xact("err_lh_mis",  1'b0, 3'b001, 32'hC01,  32'h0,        0, 32'h0, 1'b1);
      xact("err_sw_mis",  1'b1, 3'b010, 32'hC02,  32'h55555555, 0, 32'h0, 1'b1);
      xact("err_f3_011",  1'b0, 3'b011, 32'hC00,  32'h0,        0, 32'h0, 1'b1);
      xact("err_range",   1'b0, 3'b010, 32'h1000, 32'h0,        0, 32'h0, 1'b1);
      xact("after_err",   1'b0, 3'b010, 32'hC00,  32'h0,        0, 32'hABCD8034, 1'b0);

      xact("stall_lw",    1'b0, 3'b010, 32'hC00,  32'h0,        4, 32'hABCD8034, 1'b0);

      xact("sw_c04_pre",  1'b1, 3'b010, 32'hC04,  32'h5A5A5A5A, 0, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'hC04; req_wdata = 32'h11111111;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("wait_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1 check_reset_outputs("mid_reset");
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC04; req_wdata = 32'h22222222;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("mid_reset_held");
      req_valid = 1'b0;
      rst = 1'b0;
      xact("lw_c04_post", 1'b0, 3'b010, 32'hC04,  32'h0,        0, 32'h5A5A5A5A, 1'b0);

      // LATENCY=1: back-to-back requests with the consumer always ready.
      @(negedge clk);
      req_valid1 = 1'b1; req_we1 = 1'b1; req_funct31 = 3'b010; req_addr1 = 32'h10; req_wdata1 = 32'hCAFEF00D;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("l1_ready_%0d", i), 32'(req_ready1), 32'((i % 2) == 0));
         check($sformatf("l1_valid_%0d", i), 32'(rsp_valid1), 32'((i % 2) == 1));
         if (i % 2 == 1) begin
            check($sformatf("l1_rdata_%0d", i), rsp_rdata1, (i == 1) ? 32'h0 : 32'hCAFEF00D);
            check($sformatf("l1_err_%0d", i), 32'(rsp_err1), 32'd0);
            req_we1 = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      req_valid1 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that services load/store requests issued by the MEM stage over a valid/ready request channel and returns results on a valid/ready response channel.
- Has a fixed, parameterised access latency, so the pipeline can be exercised against a non-zero-latency memory.
- Handles all RV32I load/store widths: byte, halfword and word, with sign or zero extension.
- Detects misaligned, out-of-range and illegal accesses and reports them as an error response.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array. Valid byte addresses are 0 to 4*DEPTH_WORDS-1.
LATENCY, 2, cycles from request acceptance to o_rsp_valid assertion. Legal range is 1 to 15.

Ports:
i_clk  input  1  clock; all state changes on the rising edge
i_reset  input  1  asynchronous, active-high reset
i_req_valid  input  1  request present
o_req_ready  output  1  responder can accept a request
i_req_we  input  1  1 = store, 0 = load
i_req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_req_addr  input  32  byte address
i_req_wdata  input  32  store data; the low byte or halfword is used for SB/SH
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  consumer takes the response
o_rsp_rdata  output  32  load result after extension; 0 for stores and for errors
o_rsp_err  output  1  access was misaligned, out of range, or had an illegal funct3
o_busy  output  1  high in every state except IDLE

Behaviour:
- FSM states:
  - IDLE: o_req_ready=1.
  - WAIT: latency countdown.
  - RESP: o_rsp_valid=1.
- Reset values while i_reset=1 and immediately after release:
  - State is IDLE; counter is 0.
  - o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_busy=0.
  - Requests presented while i_reset=1 are ignored.
  - Array contents are not reset.
- Accept: a request is accepted on the rising edge where state=IDLE and i_req_valid=1.
  - On that edge, latch we, funct3, addr and wdata, and compute err.
  - Counter is loaded with LATENCY-1.
  - Next state is WAIT if LATENCY>1, otherwise RESP.
- WAIT: the counter decrements each cycle. On the edge where the counter equals 0:
  - Store with err=0: write the selected byte lanes into the array.
  - Load with err=0: capture o_rsp_rdata.
  - Transition to RESP.
- Latency: for a request accepted at edge N, o_rsp_valid is high after edge N+LATENCY.
- RESP: o_rsp_valid, o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready=1. On that edge:
  - Go to IDLE.
  - Clear o_rsp_valid, o_rsp_rdata and o_rsp_err.
- Throughput: at most one request per LATENCY+1 cycles. o_req_ready is low in WAIT and RESP, so a new request is never accepted in the same cycle a response completes.
- Byte lanes are little-endian. Word index = addr[ADDR_W+1:2]; lane = addr[1:0].
  - SB: write lane addr[1:0].
  - SH: write lanes {addr[1],0} and {addr[1],1}.
  - SW: write all four lanes.
- Load extension:
  - LB/LH: sign-extend the selected byte/halfword.
  - LBU/LHU: zero-extend.
  - LW: return the full word.
- err=1 when any of the following holds. On err, nothing is written and rdata is 0:
  - funct3 is 011, 110 or 111.
  - H/HU/SH with addr[0]=1.
  - W/SW with addr[1:0]!=0.
  - addr >= 4*DEPTH_WORDS.
  - Error requests still take the full LATENCY.
- Ordering: a store commits no later than the cycle its response is valid. Any load accepted afterward observes the store.
- Asynchronous reset mid-operation (WAIT or RESP):
  - Return immediately to IDLE and drop the response.
  - A store still in WAIT is not committed.
  - A store already in RESP has committed and stays committed.
- i_req_* inputs are don't-care when no request is being accepted.

Test Plan:
- SW 0xABCD1234 to 0xC00, then LW 0xC00 (LATENCY=2) -> rsp_valid exactly 2 cycles after each accept; rdata=0xABCD1234, err=0.
- SB 0x80 to 0xC01, then:
  - LB 0xC01 -> 0xFFFFFF80.
  - LBU 0xC01 -> 0x00000080.
  - LW 0xC00 -> 0xABCD8034.
  - LHU 0xC02 -> 0x0000ABCD.
- LH at 0xC01, SW at 0xC02, funct3=011 at 0xC00, LW at 0x1000 -> each gives err=1, rdata=0. A follow-up LW 0xC00 returns an unchanged value.
- Hold i_rsp_ready=0 for 4 cycles during LW 0xC00 -> rsp_valid, rdata and err stable throughout; o_req_ready=0 and o_busy=1 until the handshake edge.
- SW 0x11111111 to 0xC04 and assert i_reset during WAIT; then LW 0xC04 -> returns the pre-test value of 0xC04, not 0x11111111. All outputs are at reset values while i_reset=1.
- LATENCY=1 build, back-to-back LW with i_rsp_ready tied high -> one accept every 2 cycles; rsp_valid 1 cycle after each accept.
